// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, instruction register and fetch/execute sequencing
// against a request/acknowledge instruction memory, with a fetch timeout and sticky halt/fault.
//
// state | meaning
// IDLE  | waiting for start, no memory request
// FETCH | imemReq high at pc, waiting for imemAck (bounded by TIMEOUT)
// EXEC  | instr valid for one cycle, next pc chosen from controller inputs
// HALT  | done seen; sticky until rst
// FAULT | fetch timeout or misaligned next pc; sticky until rst
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        pcSrc,
  input  logic        jalrSel,
  input  logic        done,
  input  logic [31:0] pcTarget,
  input  logic [31:0] aluResult,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, FAULT} state_t;

  // The counter holds the number of ack-less FETCH cycles already completed,
  // so the TIMEOUT-th such cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tcnt;
  logic [31:0] pc_next;

  assign imemAddr = pc;
  assign pcPlus4  = pc + 32'd4;
  assign op       = instr[6:0];
  assign func3    = instr[14:12];
  assign func7    = instr[31:25];

  always_comb begin
    pc_next = pcPlus4;
    if (pcSrc) pc_next = jalrSel ? {aluResult[31:1], 1'b0} : pcTarget;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= '0;
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            imemReq <= 1'b1;
            tcnt    <= '0;
          end
        end
        FETCH: begin
          // an ack on the last allowed cycle still beats the timeout
          if (imemAck) begin
            instr      <= imemData;
            state      <= EXEC;
            imemReq    <= 1'b0;
            instrValid <= 1'b1;
          end else if (tcnt == TC_LAST) begin
            state   <= FAULT;
            imemReq <= 1'b0;
            fault   <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        EXEC: begin
          instrValid <= 1'b0;
          if (done) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (pc_next[1:0] != 2'b00) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pc      <= pc_next;
            state   <= FETCH;
            imemReq <= 1'b1;
            tcnt    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: the bench plays instruction memory and
// controller, predicts each executed (pc, instr) pair and the terminal status from plain rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 16;

  logic        clk = 1'b0;
  logic        rst, start, imemReq, imemAck, instrValid;
  logic        pcSrc, jalrSel, done, halted, fault;
  logic [31:0] imemAddr, imemData, instr, pc, pcPlus4, pcTarget, aluResult;
  logic [6:0]  op, func7;
  logic [2:0]  func3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_pc;
  logic [31:0] last_instr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .op(op), .func3(func3), .func7(func7), .instrValid(instrValid),
    .pc(pc), .pcPlus4(pcPlus4),
    .pcSrc(pcSrc), .jalrSel(jalrSel), .done(done),
    .pcTarget(pcTarget), .aluResult(aluResult),
    .halted(halted), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every execute cycle must match the oldest predicted fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instrValid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instrValid: got pc %h with empty scoreboard", pc);
        end else begin
          e = sb.pop_front();
          chk("exec_pc", pc, e.pc);
          chk("exec_instr", instr, e.ins);
          chk("exec_pcPlus4", pcPlus4, e.pc + 32'd4);
          chk("exec_op", {25'd0, op}, {25'd0, e.ins[6:0]});
          chk("exec_func3", {29'd0, func3}, {29'd0, e.ins[14:12]});
          chk("exec_func7", {25'd0, func7}, {25'd0, e.ins[31:25]});
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imemAck = 1'b0; imemData = '0;
    pcSrc = 1'b0; jalrSel = 1'b0; done = 1'b0; pcTarget = '0; aluResult = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk1("rst_req", imemReq, 1'b0);
    chk1("rst_valid", instrValid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    rst = 1'b0;
    model_pc   = RST_PC;
    last_instr = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge in the first FETCH cycle; returns at the negedge after EXEC.
  task automatic fetch_exec(input int dly, input logic [31:0] data, input logic d,
                            input logic s, input logic j,
                            input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] nxt;
    int          outcome;
    chk1("fetch_req", imemReq, 1'b1);
    chk("fetch_addr", imemAddr, model_pc);
    for (int i = 0; i < dly; i++) begin
      imemAck  = 1'b0;
      imemData = $urandom;
      @(negedge clk);
      chk1("fetch_wait_req", imemReq, 1'b1);
      chk1("fetch_wait_novalid", instrValid, 1'b0);
    end
    imemAck  = 1'b1;
    imemData = data;
    sb.push_back('{pc: model_pc, ins: data});
    @(negedge clk);
    // EXEC cycle: stray start/ack must be ignored
    imemAck   = 1'($urandom_range(0, 1));
    imemData  = $urandom;
    start     = 1'($urandom_range(0, 1));
    done = d; pcSrc = s; jalrSel = j; pcTarget = tgt; aluResult = alu;
    chk1("exec_valid", instrValid, 1'b1);
    chk1("exec_no_req", imemReq, 1'b0);
    last_instr = data;
    outcome = 0;
    if (d) begin
      outcome = 1;
    end else begin
      if (!s)      nxt = model_pc + 32'd4;
      else if (!j) nxt = tgt;
      else         nxt = alu & 32'hFFFF_FFFE;
      if (nxt % 4 != 0) outcome = 2;
      else              model_pc = nxt;
    end
    @(negedge clk);
    imemAck = 1'b0; start = 1'b0; done = 1'b0; pcSrc = 1'b0; jalrSel = 1'b0;
    chk1("post_valid_low", instrValid, 1'b0);
    chk("post_pc", pc, model_pc);
    chk("post_instr", instr, last_instr);
    chk1("post_halted", halted, outcome == 1);
    chk1("post_fault", fault, outcome == 2);
    chk1("post_req", imemReq, outcome == 0);
  endtask

  task automatic run_random(input int n);
    int          dly;
    logic        s, j;
    logic [31:0] tgt, alu;
    for (int k = 0; k < n; k++) begin
      dly = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      s   = 1'($urandom_range(0, 1));
      j   = 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      fetch_exec(dly, $urandom, 1'b0, s, j, tgt, alu);
    end
  endtask

  task automatic sticky_hold(input int n, input logic exp_h, input logic exp_f);
    for (int i = 0; i < n; i++) begin
      start    = 1'($urandom_range(0, 1));
      imemAck  = 1'($urandom_range(0, 1));
      imemData = $urandom;
      @(negedge clk);
      chk1("sticky_req", imemReq, 1'b0);
      chk1("sticky_valid", instrValid, 1'b0);
      chk1("sticky_halted", halted, exp_h);
      chk1("sticky_fault", fault, exp_f);
      chk("sticky_pc", pc, model_pc);
      chk("sticky_instr", instr, last_instr);
    end
    start = 1'b0; imemAck = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("idle_no_req", imemReq, 1'b0);
    end

    // sequential fetches with immediate ack, then branch, jalr, wrap, random mix, misaligned jalr
    do_start();
    for (int i = 0; i < 3; i++) fetch_exec(0, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch_exec(0, 32'h0400_0063, 1'b0, 1'b1, 1'b0, 32'h0000_0040, '0);
    fetch_exec(1, $urandom, 1'b0, 1'b1, 1'b1, '0, 32'h0000_0105);
    fetch_exec(0, $urandom, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, '0);
    fetch_exec(2, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
    run_random(40);
    fetch_exec(0, $urandom, 1'b0, 1'b1, 1'b1, '0, 32'h0000_0102);
    sticky_hold(4, 1'b0, 1'b1);

    // misaligned branch target faults too
    do_reset();
    do_start();
    fetch_exec(0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0000_0022, '0);

    // done wins over a misaligned pcSrc selection; halt is sticky, start ignored
    do_reset();
    do_start();
    run_random(5);
    fetch_exec(1, $urandom, 1'b1, 1'b1, 1'b0, 32'h0000_0013, '0);
    sticky_hold(20, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 chk1("async_rst_halted", halted, 1'b0);
    chk("async_rst_pc", pc, RST_PC);
    #1 rst = 1'b0;

    // fetch timeout without ack
    do_reset();
    do_start();
    for (int i = 1; i <= TO; i++) begin
      imemAck = 1'b0;
      @(negedge clk);
      if (i == TO - 1) begin
        chk1("to_not_yet", fault, 1'b0);
        chk1("to_still_req", imemReq, 1'b1);
      end
    end
    chk1("to_fault", fault, 1'b1);
    chk1("to_req_off", imemReq, 1'b0);
    chk("to_pc", pc, model_pc);
    sticky_hold(3, 1'b0, 1'b1);

    // ack on the last allowed cycle wins over the timeout
    do_reset();
    do_start();
    fetch_exec(TO - 1, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch_exec(TO - 1, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);

    // reset pulsed mid-fetch at pc 0x8, late ack afterwards
    do_reset();
    do_start();
    fetch_exec(0, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
    fetch_exec(0, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("mid_addr", imemAddr, 32'h0000_0008);
    #1 rst = 1'b1;
    #1 chk("mid_rst_pc", pc, RST_PC);
    chk1("mid_rst_req", imemReq, 1'b0);
    chk("mid_rst_instr", instr, 32'd0);
    #1 rst = 1'b0;
    model_pc   = RST_PC;
    last_instr = '0;
    @(negedge clk);
    imemAck  = 1'b1;
    imemData = $urandom;
    @(negedge clk);
    imemAck = 1'b0;
    chk1("late_ack_req", imemReq, 1'b0);
    chk1("late_ack_valid", instrValid, 1'b0);
    chk("late_ack_pc", pc, RST_PC);
    chk("late_ack_instr", instr, 32'd0);
    do_start();
    fetch_exec(0, $urandom, 1'b0, 1'b0, 1'b0, '0, '0);

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The module SHALL have parameter TIMEOUT, default 16, giving the maximum number of FETCH cycles without imemAck (valid range 2..255).
REQ-003 Port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  begins fetching from RESET_PC; sampled only in IDLE.
REQ-006 Port imemReq  output  1  instruction-memory read request.
REQ-007 Port imemAddr  output  32  read address; equals pc.
REQ-008 Port imemAck  input  1  imemData valid this cycle.
REQ-009 Port imemData  input  32  fetched instruction word.
REQ-010 Port instr  output  32  instruction register.
REQ-011 Port op / func3 / func7  output  7 / 3 / 7  equal to instr[6:0], instr[14:12] and instr[31:25] respectively.
REQ-012 Port instrValid  output  1  execute cycle; the controller and datapath act on instr this cycle.
REQ-013 Port pc / pcPlus4  output  32 / 32  current PC and pc+4 (modulo 2^32).
REQ-014 Port pcSrc, jalrSel, done  input  1 each  controller decisions, sampled only when instrValid=1.
REQ-015 Port pcTarget  input  32  pc+imm branch/jal target.
REQ-016 Port aluResult  input  32  jalr target before LSB clear.
REQ-017 Port halted / fault  output  1 / 1  sticky terminal status flags.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC, HALT and FAULT.
REQ-019 IDLE: imemReq=0; on start=1 the FSM SHALL go to FETCH.
REQ-020 FETCH: imemReq=1 and imemAddr=pc; on an imemAck=1 edge, instr SHALL take imemData and the FSM SHALL go to EXEC. An ack in the first FETCH cycle is legal, giving a minimum of 2 cycles per instruction.
REQ-021 EXEC: instrValid=1 for exactly one cycle and imemReq=0; pc and instr SHALL be stable throughout.
REQ-022 EXEC exit with done=1: the FSM SHALL go to HALT with pc unchanged; pcSrc is ignored.
REQ-023 EXEC exit with done=0, pcSrc=0: next pc SHALL be pc+4, with wrap 32'hFFFF_FFFC -> 0.
REQ-024 EXEC exit with done=0, pcSrc=1, jalrSel=0: next pc SHALL be pcTarget.
REQ-025 EXEC exit with done=0, pcSrc=1, jalrSel=1: next pc SHALL be {aluResult[31:1],1'b0}.
REQ-026 If the selected next pc has bits [1:0] != 0, the FSM SHALL go to FAULT with pc unchanged; otherwise it SHALL go to FETCH.
REQ-027 A timeout counter SHALL clear on FETCH entry and increment on each FETCH cycle without ack.
REQ-028 On the TIMEOUT-th consecutive FETCH cycle without ack, the FSM SHALL go to FAULT; an ack in that same cycle SHALL win and the FSM SHALL go to EXEC.
REQ-029 HALT SHALL assert halted=1 and FAULT SHALL assert fault=1; both states SHALL be left only by rst, with imemReq=0 and instrValid=0.
REQ-030 start outside IDLE and imemAck outside FETCH SHALL be ignored.
REQ-031 instr SHALL hold its last value in all states except on a FETCH ack edge.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force state IDLE, pc=RESET_PC, instr=0, imemReq=0, instrValid=0, halted=0, fault=0 and timeout counter=0.
REQ-033 Reset asserted mid-FETCH SHALL drop imemReq in the same cycle, and a late imemAck after release SHALL be ignored.
REQ-034 After rst deasserts, the FSM SHALL remain in IDLE until start=1.

Verification
REQ-035 Ack same cycle as request, pcSrc=0, start pulse -> imemAddr 0x0, 0x4, 0x8 on successive fetches; instrValid pulses every 2nd cycle.
REQ-036 imemData=0x0400_0063 (beq), pcSrc=1, jalrSel=0, pcTarget=0x40 -> op=7'h63, func3=0; next imemAddr=0x40.
REQ-037 jalrSel=1, pcSrc=1, aluResult=0x105 -> next pc 0x104; aluResult=0x102 -> fault=1, pc unchanged, imemReq=0.
REQ-038 done=1 in EXEC -> halted=1 next cycle; no further imemReq for 20 cycles; start is ignored.
REQ-039 TIMEOUT=16 with no ack -> fault=1 after the 16th FETCH cycle; a repeat run with ack on cycle 16 -> EXEC, fault=0.
REQ-040 rst pulsed mid-FETCH with pc=0x8 -> pc=RESET_PC and imemReq=0 before the next clk edge; an ack 1 cycle later changes no state.
